// File: rtl/rst_stage_seq.sv
// rst_stage_seq: power-up reset sequencer.
// Releases per-subsystem resets one stage at a time. Each stage's reset is
// held for STAGE_DLY cycles, then released. The sequencer then waits up to
// READY_TIMEOUT cycles for that stage's ready before moving on. Timeouts
// restart the whole sequence up to MAX_RETRY times, then latch a fault.
// Optional build macro: RST_STAGE_SEQ_READY_SYNC_EN adds a 2-flop
// synchronizer on every stage_ready bit.
module rst_stage_seq #(
  parameter int N_STAGES      = 4,
  parameter int STAGE_DLY     = 1000,
  parameter int READY_TIMEOUT = 50000,
  parameter int MAX_RETRY     = 3
) (
  input  logic                clk,
  input  logic                rst_sys,
  input  logic                soft_rst_req,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic                init_done,
  output logic                init_fault,
  output logic [2:0]          fault_stage,
  output logic [3:0]          retry_cnt
);

  localparam int T_MAX = (STAGE_DLY > READY_TIMEOUT) ? STAGE_DLY : READY_TIMEOUT;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int IW    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [TW-1:0] HOLD_LAST = TW'(STAGE_DLY - 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(READY_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_STAGES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [IW-1:0]       idx_reg, idx_next;
  logic [TW-1:0]       timer_reg, timer_next;
  logic [N_STAGES-1:0] stage_rst_reg, stage_rst_next;
  logic                done_reg, done_next;
  logic                fault_reg, fault_next;
  logic [2:0]          fault_stage_reg, fault_stage_next;
  logic [3:0]          retry_reg, retry_next;
  logic [N_STAGES-1:0] ready_use;

`ifdef RST_STAGE_SEQ_READY_SYNC_EN
  logic [N_STAGES-1:0] ready_meta_reg;
  logic [N_STAGES-1:0] ready_sync_reg;

  // Two-flop synchronizer; cleared by either reset source so a restart
  // never acts on stale ready levels.
  always_ff @(posedge clk) begin
    if (rst_sys || soft_rst_req) begin
      ready_meta_reg <= '0;
      ready_sync_reg <= '0;
    end else begin
      ready_meta_reg <= stage_ready;
      ready_sync_reg <= ready_meta_reg;
    end
  end

  assign ready_use = ready_sync_reg;
`else
  assign ready_use = stage_ready;
`endif

  // State and output registers; rst_sys outranks everything else.
  always_ff @(posedge clk) begin
    if (rst_sys) begin
      state_reg       <= HOLD;
      idx_reg         <= '0;
      timer_reg       <= '0;
      stage_rst_reg   <= '1;
      done_reg        <= 1'b0;
      fault_reg       <= 1'b0;
      fault_stage_reg <= '0;
      retry_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      idx_reg         <= idx_next;
      timer_reg       <= timer_next;
      stage_rst_reg   <= stage_rst_next;
      done_reg        <= done_next;
      fault_reg       <= fault_next;
      fault_stage_reg <= fault_stage_next;
      retry_reg       <= retry_next;
    end
  end

  // Next-state logic: soft restart first, then the sequencing FSM.
  always_comb begin
    state_next       = state_reg;
    idx_next         = idx_reg;
    timer_next       = timer_reg;
    stage_rst_next   = stage_rst_reg;
    done_next        = done_reg;
    fault_next       = fault_reg;
    fault_stage_next = fault_stage_reg;
    retry_next       = retry_reg;

    if (soft_rst_req) begin
      // fault_stage is left as-is so the last failing stage stays readable.
      state_next     = HOLD;
      idx_next       = '0;
      timer_next     = '0;
      stage_rst_next = '1;
      done_next      = 1'b0;
      fault_next     = 1'b0;
      retry_next     = '0;
    end else begin
      case (state_reg)
        HOLD: begin
          if (timer_reg == HOLD_LAST) begin
            stage_rst_next[idx_reg] = 1'b0;
            timer_next              = '0;
            state_next              = WAIT;
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        WAIT: begin
          // Ready is checked before the timeout so a same-cycle collision advances.
          if (ready_use[idx_reg]) begin
            timer_next = '0;
            if (idx_reg == IDX_LAST) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              idx_next   = idx_reg + 1'b1;
              state_next = HOLD;
            end
          end else if (timer_reg == WAIT_LAST) begin
            timer_next     = '0;
            stage_rst_next = '1;
            idx_next       = '0;
            if (retry_reg < RETRY_MAX) begin
              retry_next = retry_reg + 1'b1;
              state_next = HOLD;
            end else begin
              state_next       = FAULT;
              fault_next       = 1'b1;
              fault_stage_next = 3'(idx_reg);
            end
          end else begin
            timer_next = timer_reg + 1'b1;
          end
        end
        DONE: begin
          done_next      = 1'b1;
          stage_rst_next = '0;
          // Losing any ready after init restarts the sequence with fresh retries.
          if (!(&ready_use)) begin
            done_next      = 1'b0;
            stage_rst_next = '1;
            retry_next     = '0;
            idx_next       = '0;
            timer_next     = '0;
            state_next     = HOLD;
          end
        end
        FAULT: begin
          fault_next     = 1'b1;
          stage_rst_next = '1;
        end
        default: begin
          state_next = HOLD;
        end
      endcase
    end
  end

  assign stage_rst   = stage_rst_reg;
  assign init_done   = done_reg;
  assign init_fault  = fault_reg;
  assign fault_stage = fault_stage_reg;
  assign retry_cnt   = retry_reg;

endmodule

// File: tb/tb_rst_stage_seq.sv
// Scoreboard bench for rst_stage_seq: expectations are queued with the cycle
// they must appear in, and a negedge monitor pops and compares them.
module tb_rst_stage_seq;
  localparam int N = 3;
  localparam int D = 4;
  localparam int T = 8;
  localparam int R = 1;

  logic         clk = 1'b0;
  logic         rst_sys = 1'b1;
  logic         soft_rst_req = 1'b0;
  logic [N-1:0] stage_ready = '0;
  logic [N-1:0] stage_rst;
  logic         init_done;
  logic         init_fault;
  logic [2:0]   fault_stage;
  logic [3:0]   retry_cnt;

  rst_stage_seq #(
    .N_STAGES(N), .STAGE_DLY(D), .READY_TIMEOUT(T), .MAX_RETRY(R)
  ) dut (
    .clk(clk), .rst_sys(rst_sys), .soft_rst_req(soft_rst_req),
    .stage_ready(stage_ready), .stage_rst(stage_rst), .init_done(init_done),
    .init_fault(init_fault), .fault_stage(fault_stage), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // -1 in a field means "not compared".
  typedef struct {
    int    cyc;
    string tag;
    int    srst;
    int    done;
    int    fault;
    int    fs;
    int    retry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic expect_at(input int c, input string tag, input int srst,
                           input int done, input int fault, input int fs, input int retry);
    exp_t e;
    int   i;
    e.cyc = c; e.tag = tag; e.srst = srst; e.done = done;
    e.fault = fault; e.fs = fs; e.retry = retry;
    i = 0;
    while (i < sb.size() && sb[i].cyc <= c) i++;
    sb.insert(i, e);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.cyc < cyc) begin
        check({mon_e.tag, "/missed"}, cyc, mon_e.cyc);
      end else begin
        $display("cyc %0d %s: stage_rst=%b done=%0d fault=%0d fault_stage=%0d retry=%0d",
                 cyc, mon_e.tag, stage_rst, init_done, init_fault, fault_stage, retry_cnt);
        check({mon_e.tag, "/stage_rst"}, int'(stage_rst), mon_e.srst);
        check({mon_e.tag, "/init_done"}, int'(init_done), mon_e.done);
        check({mon_e.tag, "/init_fault"}, int'(init_fault), mon_e.fault);
        if (mon_e.fs >= 0) check({mon_e.tag, "/fault_stage"}, int'(fault_stage), mon_e.fs);
        check({mon_e.tag, "/retry_cnt"}, int'(retry_cnt), mon_e.retry);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // stage_rst value with stages 0..k-1 released
  function automatic int rel(input int k);
    return ((1 << N) - 1) & ~((1 << k) - 1);
  endfunction

  // Called on the cycle stage i's reset is first seen low: raise its ready
  // two cycles later and expect the next release / init_done.
  task automatic run_stage(input int i, input int retry, input int fs);
    int r;
    tick(2);
    stage_ready[i] = 1'b1;
    r = cyc;
    if (i < N - 1) begin
      expect_at(r + D,     $sformatf("stage%0d_hold", i + 1), rel(i + 1), 0, 0, fs, retry);
      expect_at(r + D + 1, $sformatf("stage%0d_rel", i + 1),  rel(i + 2), 0, 0, fs, retry);
      tick(D + 1);
    end else begin
      expect_at(r + 1, "init_done", 0, 1, 0, fs, retry);
      tick(1);
    end
  endtask

  initial begin
    int h, w, r, s, guard;

    // Reset state
    tick(1);
    expect_at(cyc + 1, "reset", 7, 0, 0, 0, 0);
    tick(2);

    // Nominal sequence
    rst_sys = 1'b0;
    h = cyc;
    expect_at(h + D - 1, "nom_hold0", 7, 0, 0, 0, 0);
    expect_at(h + D,     "nom_rel0",  6, 0, 0, 0, 0);
    tick(D);
    for (int i = 0; i < N; i++) run_stage(i, 0, 0);
    tick(3);
    expect_at(cyc + 1, "nom_done_hold", 0, 1, 0, 0, 0);
    tick(1);

    // Loss of ready after init
    stage_ready[0] = 1'b0;
    expect_at(cyc + 1, "loss", 7, 0, 0, 0, 0);
    tick(1);
    stage_ready = '0;
    h = cyc;
    expect_at(h + D - 1, "loss_hold0", 7, 0, 0, 0, 0);
    expect_at(h + D,     "loss_rel0",  6, 0, 0, 0, 0);
    tick(D);
    w = cyc;

    // Ready on the last WAIT cycle wins over the timeout
    tick(T - 1);
    stage_ready[0] = 1'b1;
    r = cyc;
    expect_at(r + 1,     "collide",       6, 0, 0, 0, 0);
    expect_at(r + D,     "collide_hold1", 6, 0, 0, 0, 0);
    expect_at(r + D + 1, "collide_rel1",  4, 0, 0, 0, 0);
    tick(D + 1);
    w = cyc;

    // Stage 1 never ready: retry, then fault
    expect_at(w + T - 1, "to1_wait",  4, 0, 0, 0, 0);
    expect_at(w + T,     "to1_retry", 7, 0, 0, 0, 1);
    tick(T);
    stage_ready = '0;
    h = cyc;
    expect_at(h + D - 1, "retry_hold0", 7, 0, 0, 0, 1);
    expect_at(h + D,     "retry_rel0",  6, 0, 0, 0, 1);
    tick(D);
    run_stage(0, 1, 0);
    w = cyc;
    expect_at(w + T - 1,  "to2_wait",       4, 0, 0, 0, 1);
    expect_at(w + T,      "to2_fault",      7, 0, 1, 1, 1);
    expect_at(w + T + 12, "to2_fault_hold", 7, 0, 1, 1, 1);
    tick(T + 12);

    // Soft restart from fault
    soft_rst_req = 1'b1;
    stage_ready = '0;
    s = cyc;
    expect_at(s + 1, "soft", 7, 0, 0, -1, 0);
    tick(1);
    soft_rst_req = 1'b0;
    expect_at(s + D,     "soft_hold0", 7, 0, 0, -1, 0);
    expect_at(s + D + 1, "soft_rel0",  6, 0, 0, -1, 0);
    tick(D);
    run_stage(0, 0, -1);
    run_stage(1, 0, -1);

    // rst_sys while waiting on stage 2
    tick(3);
    rst_sys = 1'b1;
    expect_at(cyc + 1, "mid_reset", 7, 0, 0, 0, 0);
    tick(1);
    stage_ready = '0;
    expect_at(cyc + 2, "mid_reset_hold", 7, 0, 0, 0, 0);
    tick(3);

    guard = 0;
    while (sb.size() > 0 && guard < 100) begin
      tick(1);
      guard++;
    end
    if (sb.size() > 0) check("scoreboard_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
